// File: rtl/fyp_gen_pkg.sv
// Shared encodings and constants for the burst generator and its PRBS31 source.
package fyp_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] MODE_ZERO     = 2'd0;
    localparam logic [1:0] MODE_INC      = 2'd1;
    localparam logic [1:0] MODE_PRBS     = 2'd2;
    localparam logic [1:0] MODE_ZERO_ALT = 2'd3;

    localparam int DEF_MIN_LEN    = 60;
    localparam int DEF_MAX_LEN    = 1514;
    localparam int PRBS_TAP_A     = 31;
    localparam int PRBS_TAP_B     = 28;
    localparam int BYTES_PER_BEAT = 4;
    localparam int HDR_LEN        = 14;

    // Runs the x^31+x^28+1 recurrence 32 times; returns {next_state, word}, first bit in word[31].
    function automatic logic [62:0] prbs31_step32(input logic [30:0] state);
        logic [30:0] st;
        logic [31:0] wd;
        logic        nb;
        st = state;
        wd = '0;
        for (int i = 0; i < 32; i++) begin
            nb         = st[PRBS_TAP_A-1] ^ st[PRBS_TAP_B-1];
            wd[31-i]   = nb;
            st         = {st[29:0], nb};
        end
        return {st, wd};
    endfunction

endpackage

// File: rtl/fyp_prbs31.sv
// PRBS31 word source: presents one 32-bit word, steps to the next on i_advance.
module fyp_prbs31
    import fyp_gen_pkg::*;
#(
    parameter logic [30:0] SEED = 31'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_advance,
    output logic [31:0] o_word
);

    logic [30:0] r_state;
    logic [62:0] w_step;

    assign w_step = prbs31_step32(r_state);
    assign o_word = w_step[31:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= w_step[62:32];
        end
    end

endmodule

// File: rtl/fyp_burst_generator.sv
// Ethernet burst generator driving the TSE MAC Avalon-ST transmit port (32-bit, readyLatency 0).
module fyp_burst_generator
    import fyp_gen_pkg::*;
#(
    parameter int          LEN_W     = 11,
    parameter int          CNT_W     = 16,
    parameter int          GAP_W     = 16,
    parameter int          MIN_LEN   = DEF_MIN_LEN,
    parameter int          MAX_LEN   = DEF_MAX_LEN,
    parameter logic [30:0] PRBS_SEED = 31'h7FFF_FFFF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             gen_start,
    input  logic             gen_stop,
    input  logic [47:0]      cfg_dst_mac,
    input  logic [47:0]      cfg_src_mac,
    input  logic [15:0]      cfg_ethertype,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic [31:0]      tx_data,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             tx_valid,
    output logic [1:0]       tx_empty,
    output logic             tx_err,
    input  logic             tx_rdy,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_count
);

    logic r_start_s1, r_start_s2, r_start_d;
    logic r_stop_s1, r_stop_s2, r_stop_d;
    logic w_start_edge, w_stop_edge;

    logic [1:0]       r_state;
    logic [47:0]      r_dst, r_src;
    logic [15:0]      r_type;
    logic [LEN_W-1:0] r_len;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_burst, r_burst_cnt, r_pkt_count;
    logic [GAP_W-1:0] r_gap, r_gap_cnt;
    logic [LEN_W-1:0] r_beat;
    logic             r_stop_pend;
    logic             r_done;

    logic [LEN_W-1:0] w_len_clamped;
    logic [LEN_W-1:0] w_nbeats;
    logic             w_valid, w_accept, w_last, w_end_burst;
    logic [1:0]       w_empty;
    logic [7:0]       w_pidx;
    logic [31:0]      w_pay, w_beat_data, w_prbs_word;
    logic [15:0]      w_p01;
    logic             w_prbs_adv;

    // Start/stop are asynchronous levels: two-flop synchronise, then detect rising edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {r_start_s1, r_start_s2, r_start_d} <= '0;
            {r_stop_s1, r_stop_s2, r_stop_d}    <= '0;
        end else begin
            {r_start_d, r_start_s2, r_start_s1} <= {r_start_s2, r_start_s1, gen_start};
            {r_stop_d, r_stop_s2, r_stop_s1}    <= {r_stop_s2, r_stop_s1, gen_stop};
        end
    end

    assign w_start_edge = r_start_s2 & ~r_start_d;
    assign w_stop_edge  = r_stop_s2 & ~r_stop_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_len_clamped = cfg_frame_len;
        if (cfg_frame_len < LEN_W'(MIN_LEN)) begin
            w_len_clamped = LEN_W'(MIN_LEN);
        end else if (cfg_frame_len > LEN_W'(MAX_LEN)) begin
            w_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    assign w_nbeats    = (r_len + LEN_W'(BYTES_PER_BEAT - 1)) / LEN_W'(BYTES_PER_BEAT);
    assign w_last      = (r_beat == w_nbeats - LEN_W'(1));
    assign w_valid     = (r_state == ST_SEND);
    assign w_accept    = w_valid & tx_rdy;
    assign w_empty     = 2'(3'd4 - {1'b0, r_len[1:0]});
    assign w_end_burst = r_stop_pend | w_stop_edge |
                         ((r_burst != '0) && (r_burst_cnt + CNT_W'(1) == r_burst));
    assign w_prbs_adv  = w_accept && (r_mode == MODE_PRBS) && (r_beat >= LEN_W'(3));

    fyp_prbs31 #(
        .SEED      (PRBS_SEED)
    ) u_prbs (
        .clk       (clk),
        .resetn    (resetn),
        .i_advance (w_prbs_adv),
        .o_word    (w_prbs_word)
    );

    // Payload byte index of the first byte lane in this beat (wraps naturally to i[7:0]).
    always_comb begin
        w_pidx = {r_beat[5:0], 2'b00} - 8'(HDR_LEN);
        w_pay  = '0;
        case (r_mode)
            MODE_INC:      w_pay = {w_pidx, w_pidx + 8'd1, w_pidx + 8'd2, w_pidx + 8'd3};
            MODE_PRBS:     w_pay = w_prbs_word;
            MODE_ZERO:     w_pay = '0;
            MODE_ZERO_ALT: w_pay = '0;
            default:       w_pay = '0;
        endcase
        w_p01 = (r_mode == MODE_PRBS) ? w_prbs_word[31:16] : w_pay[15:0];
        case (r_beat)
            LEN_W'(0): w_beat_data = r_dst[47:16];
            LEN_W'(1): w_beat_data = {r_dst[15:0], r_src[47:32]};
            LEN_W'(2): w_beat_data = r_src[31:0];
            LEN_W'(3): w_beat_data = {r_type, w_p01};
            default:   w_beat_data = w_pay;
        endcase
    end

    assign tx_valid  = w_valid;
    assign tx_data   = w_valid ? w_beat_data : '0;
    assign tx_sop    = w_valid && (r_beat == '0);
    assign tx_eop    = w_valid && w_last;
    assign tx_empty  = (w_valid && w_last) ? w_empty : 2'd0;
    assign tx_err    = 1'b0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign pkt_count = r_pkt_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_dst       <= '0;
            r_src       <= '0;
            r_type      <= '0;
            r_len       <= '0;
            r_mode      <= '0;
            r_burst     <= '0;
            r_gap       <= '0;
            r_beat      <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_pkt_count <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge && !w_stop_edge) begin
                        r_dst       <= cfg_dst_mac;
                        r_src       <= cfg_src_mac;
                        r_type      <= cfg_ethertype;
                        r_len       <= w_len_clamped;
                        r_mode      <= cfg_mode;
                        r_burst     <= cfg_burst;
                        r_gap       <= cfg_gap;
                        r_beat      <= '0;
                        r_burst_cnt <= '0;
                        r_stop_pend <= 1'b0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_stop_edge) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_last) begin
                            r_pkt_count <= r_pkt_count + CNT_W'(1);
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                            r_beat      <= '0;
                            if (w_end_burst) begin
                                r_state     <= ST_IDLE;
                                r_done      <= 1'b1;
                                r_stop_pend <= 1'b0;
                            end else if (r_gap != '0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= '0;
                            end
                        end else begin
                            r_beat <= r_beat + LEN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_stop_edge || r_stop_pend) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end else if (r_gap_cnt == r_gap - GAP_W'(1)) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
